// File: rtl/cyc_counter_monitor.sv
// Observation-only checker for the selector-driven cyclic counter: replays the
// legal update rule on the sampled c/n values, flags divergences and counts wraps.
module cyc_counter_monitor #(
   parameter int W        = 11,
   parameter int N_RESET  = 200,
   parameter int WRAP_VAL = 1,
   parameter int WCNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              selector,
   input  logic [W-1:0]      c_obs,
   input  logic [W-1:0]      n_obs,
   input  logic              clear_err,
   output logic [1:0]        state,
   output logic [3:0]        err_flags,
   output logic              err_pulse,
   output logic [WCNT_W-1:0] wrap_count,
   output logic              in_sync
);

   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, TRACK = 2'd2, FAULT = 2'd3} state_t;

   localparam logic [W-1:0] WRAP_C  = W'(WRAP_VAL);
   localparam logic [W-1:0] NRST_C  = W'(N_RESET);
   localparam logic [W-1:0] ONE_C   = W'(1);

   state_t          st, st_nxt;
   logic [W-1:0]    prev_c, prev_n;
   logic            prev_sel;
   logic            first_arm;
   logic [W-1:0]    exp_c;
   logic            bound_err, step_err, nchg_err, init_err;
   logic [3:0]      new_err;
   logic            wrap_hit;

   assign state = st;

   // Expected c for this edge, derived purely from the previous sample.
   always_comb begin
      exp_c = prev_c;
      if (prev_sel) begin
         if (prev_c == prev_n) exp_c = WRAP_C;
         else                  exp_c = prev_c + ONE_C;
      end
   end

   assign bound_err = (c_obs > n_obs);
   assign step_err  = (c_obs != exp_c);
   assign nchg_err  = (n_obs != prev_n);
   assign init_err  = (c_obs != '0) || (n_obs != NRST_C);

   always_comb begin
      st_nxt   = st;
      new_err  = 4'b0000;
      wrap_hit = 1'b0;
      case (st)
         IDLE: st_nxt = ARM;
         ARM: begin
            // Only the ARM right after reset sees the counter's reset values;
            // a resync ARM just adopts the current sample as baseline.
            new_err = {first_arm && init_err, 2'b00, bound_err};
            st_nxt  = (|new_err) ? FAULT : TRACK;
         end
         TRACK: begin
            new_err = {1'b0, nchg_err, step_err, bound_err};
            if (|new_err) st_nxt = FAULT;
            else wrap_hit = prev_sel && (prev_c == prev_n) && (c_obs == WRAP_C);
         end
         FAULT: begin
            new_err = {1'b0, nchg_err, step_err, bound_err};
            if (clear_err && !(|new_err)) st_nxt = ARM;
         end
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= IDLE;
         prev_c     <= '0;
         prev_n     <= '0;
         prev_sel   <= 1'b0;
         first_arm  <= 1'b1;
         err_flags  <= 4'b0000;
         err_pulse  <= 1'b0;
         wrap_count <= '0;
         in_sync    <= 1'b0;
      end else begin
         st        <= st_nxt;
         prev_c    <= c_obs;
         prev_n    <= n_obs;
         prev_sel  <= selector;
         if (st == ARM) first_arm <= 1'b0;
         err_flags <= (clear_err ? 4'b0000 : err_flags) | new_err;
         err_pulse <= |new_err;
         in_sync   <= (st_nxt == TRACK);
         if (wrap_hit && (wrap_count != {WCNT_W{1'b1}}))
            wrap_count <= wrap_count + 1'b1;
      end
   end

endmodule
